// File: rtl/debug_mem_loader.sv
// Debug loader for RV32ICore: streams a data and an instruction segment into the caches,
// runs the core for a fixed window, then dumps both caches word by word.
module debug_mem_loader #(
    parameter int BRAMWORDS  = 4096,
    parameter int RST_CYCLES = 4,
    parameter int RUN_CYCLES = 200000
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sel,
    output logic        out_last,
    output logic [31:0] dc_a2,
    output logic [31:0] dc_wd2,
    output logic [3:0]  dc_we2,
    input  logic [31:0] dc_rd2,
    output logic [31:0] ic_a2,
    output logic [31:0] ic_wd2,
    output logic [3:0]  ic_we2,
    input  logic [31:0] ic_rd2,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int K_W     = $clog2(BRAMWORDS + 1);
    localparam int CNT_MAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [K_W-1:0]   K_END     = K_W'(BRAMWORDS);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(BRAMWORDS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_D, LOAD_I, RST_HOLD, RUN, DUMP_D, DUMP_I, DONE
    } StateT;

    StateT            state;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       dumpPh;
    logic             inFire;

    // Word index to byte address; upper address bits stay zero.
    function automatic logic [31:0] byteAddr(input logic [K_W-1:0] idx);
        byteAddr = {{(32 - K_W){1'b0}}, idx} << 2;
    endfunction

    assign inFire = in_valid & in_ready;

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sel   <= 1'b0;
            out_data  <= '0;
            dc_a2     <= '0;
            dc_wd2    <= '0;
            dc_we2    <= '0;
            ic_a2     <= '0;
            ic_wd2    <= '0;
            ic_we2    <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            k         <= '0;
            cnt       <= '0;
            dumpPh    <= '0;
        end else begin
            dc_we2 <= 4'b0000;
            ic_we2 <= 4'b0000;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD_D;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        k        <= '0;
                    end
                end

                LOAD_D, LOAD_I: begin
                    if (inFire) begin
                        if (k < K_END) begin
                            if (state == LOAD_D) begin
                                dc_a2  <= byteAddr(k);
                                dc_wd2 <= in_data;
                                dc_we2 <= 4'b1111;
                            end else begin
                                ic_a2  <= byteAddr(k);
                                ic_wd2 <= in_data;
                                ic_we2 <= 4'b1111;
                            end
                            k <= k + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        if (in_last) begin
                            k <= '0;
                            if (state == LOAD_D) begin
                                state <= LOAD_I;
                            end else begin
                                state    <= RST_HOLD;
                                in_ready <= 1'b0;
                                cnt      <= '0;
                            end
                        end
                    end
                end

                RST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state    <= RUN;
                        cnt      <= '0;
                        core_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (cnt == RUN_LAST) begin
                        state    <= DUMP_D;
                        core_rst <= 1'b1;
                        cnt      <= '0;
                        k        <= '0;
                        dumpPh   <= 2'd0;
                        dc_a2    <= byteAddr('0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DUMP_D, DUMP_I: begin
                    // Phase 0 waits out the cache read latency, phase 1 captures rd2,
                    // phase 2 holds the word until the consumer takes it.
                    case (dumpPh)
                        2'd0: dumpPh <= 2'd1;
                        2'd1: begin
                            out_data  <= (state == DUMP_D) ? dc_rd2 : ic_rd2;
                            out_valid <= 1'b1;
                            out_sel   <= (state == DUMP_I);
                            out_last  <= (k == K_LAST);
                            dumpPh    <= 2'd2;
                        end
                        default: begin
                            if (out_ready) begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                dumpPh    <= 2'd0;
                                if (k == K_LAST) begin
                                    k <= '0;
                                    if (state == DUMP_D) begin
                                        state <= DUMP_I;
                                        ic_a2 <= byteAddr('0);
                                    end else begin
                                        state <= DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end else begin
                                    k <= k + 1'b1;
                                    if (state == DUMP_D) dc_a2 <= byteAddr(k + 1'b1);
                                    else                 ic_a2 <= byteAddr(k + 1'b1);
                                end
                            end
                        end
                    endcase
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
